fp_divider: RTL and testbench

FP_DIVIDER -- requirements
Module: fp_divider

---
 rtl/fp_pkg.sv | 43 ++++
 rtl/fp_classify.sv | 27 ++
 rtl/fp_divider.sv | 178 +++++++++++++++++
 tb/tb_fp_divider.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point package for the divider and multiplier.
// Holds the controller state encoding, derivation of exponent/mantissa
// widths and bias from the operand width, and canonical positive-signed
// special values. Callers OR in the result sign at bit X-1.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_DIVIDE = 3'd2,
        ST_NORM   = 3'd3,
        ST_DONE   = 3'd4
    } fp_state_t;

    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
    localparam logic [31:0] INF_SP  = 32'h7F80_0000;
    localparam logic [31:0] ZERO_SP = 32'h0000_0000;
    localparam logic [63:0] QNAN_DP = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] INF_DP  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] ZERO_DP = 64'h0000_0000_0000_0000;

    function automatic int expo_bits_of(input int x);
        return (x == 64) ? 11 : 8;
    endfunction

    function automatic int mant_bits_of(input int x);
        return (x == 64) ? 52 : 23;
    endfunction

    function automatic int bias_of(input int x);
        return (x == 64) ? 1023 : 127;
    endfunction

    // Canonical values returned right-aligned in 64 bits.
    function automatic logic [63:0] qnan_of(input int x);
        return (x == 64) ? QNAN_DP : {32'h0, QNAN_SP};
    endfunction

    function automatic logic [63:0] inf_of(input int x);
        return (x == 64) ? INF_DP : {32'h0, INF_SP};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier.
// Ports: mag (operand without sign bit) -> is_zero, is_inf, is_nan.
// Subnormals (exp=0, mant!=0) report as zero, which flushes them.
module fp_classify
    import fp_pkg::*;
#(
    parameter int X = 32
) (
    input  logic [X-2:0] mag,
    output logic         is_zero,
    output logic         is_inf,
    output logic         is_nan
);

    localparam int EB = expo_bits_of(X);
    localparam int MB = mant_bits_of(X);

    logic [EB-1:0] expo;
    logic [MB-1:0] mant;

    assign expo    = mag[X-2 -: EB];
    assign mant    = mag[MB-1:0];
    assign is_zero = (expo == '0);
    assign is_inf  = (expo == '1) && (mant == '0);
    assign is_nan  = (expo == '1) && (mant != '0);

endmodule

// File: rtl/fp_divider.sv
// Multi-cycle IEEE-754 divider (single or double precision), truncating.
// Ports: clk, rst (async, active high), start, A (dividend), B (divisor)
//        -> out (registered quotient), done (1-cycle pulse), busy.
//
// state  | meaning
// IDLE   | waiting for start, operands captured on accept
// CHECK  | classify operands; specials finish here, else set up divide
// DIVIDE | restoring division, one quotient bit per cycle (down-counter)
// NORM   | normalise, range-check exponent, register result
// DONE   | done pulse; always returns to IDLE
module fp_divider
    import fp_pkg::*;
#(
    parameter int X = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [X-1:0] A,
    input  logic [X-1:0] B,
    output logic [X-1:0] out,
    output logic         done,
    output logic         busy
);

    localparam int EB   = expo_bits_of(X);
    localparam int MB   = mant_bits_of(X);
    localparam int BIAS = bias_of(X);
    localparam int EW   = EB + 2;
    localparam int CW   = $clog2(MB + 2);

    localparam logic [63:0]          QNAN_W = qnan_of(X);
    localparam logic [63:0]          INF_W  = inf_of(X);
    localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EB) - 1);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic [CW-1:0]        CNT_LOAD = CW'(MB + 1);

    fp_state_t state_q, state_d;

    logic [X-1:0]           a_q, b_q;
    logic [MB+1:0]          rem_q, quo_q;
    logic signed [EW-1:0]   expo_q;
    logic [CW-1:0]          cnt_q;
    logic [X-1:0]           out_d;
    logic                   done_d;

    logic                   sign;
    logic                   zero_a, inf_a, nan_a, zero_b, inf_b, nan_b;
    logic                   special;
    logic [X-1:0]           special_res, normal_res;
    logic [MB+1:0]          div_v, rem_nx;
    logic                   ge;
    logic [MB-1:0]          frac;
    logic signed [EW-1:0]   expo_n;

    assign sign = a_q[X-1] ^ b_q[X-1];

    fp_classify #(.X(X)) u_class_a (
        .mag     (a_q[X-2:0]),
        .is_zero (zero_a),
        .is_inf  (inf_a),
        .is_nan  (nan_a)
    );

    fp_classify #(.X(X)) u_class_b (
        .mag     (b_q[X-2:0]),
        .is_zero (zero_b),
        .is_inf  (inf_b),
        .is_nan  (nan_b)
    );

    always_comb begin
        special     = 1'b1;
        special_res = {sign, {(X-1){1'b0}}};
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
            special_res = {sign, QNAN_W[X-2:0]};
        else if (inf_a || zero_b)
            special_res = {sign, INF_W[X-2:0]};
        else if (zero_a || inf_b)
            special_res = {sign, {(X-1){1'b0}}};
        else
            special = 1'b0;
    end

    // Remainder stays below 2*divisor, so MB+2 bits suffice; the difference
    // is taken modulo 2^(MB+2) because the true value is below the divisor.
    assign div_v  = {2'b01, b_q[MB-1:0]};
    assign ge     = (rem_q >= div_v);
    assign rem_nx = ge ? (rem_q - div_v) : rem_q;

    // Quotient lies in (0.5, 2); a clear integer bit means one left shift.
    always_comb begin
        frac       = quo_q[MB+1] ? quo_q[MB:1] : quo_q[MB-1:0];
        expo_n     = quo_q[MB+1] ? expo_q : (expo_q - E_ONE);
        if (expo_n >= E_MAX)
            normal_res = {sign, INF_W[X-2:0]};
        else if (expo_n <= E_ZERO)
            normal_res = {sign, {(X-1){1'b0}}};
        else
            normal_res = {sign, expo_n[EB-1:0], frac};
    end

    always_comb begin
        state_d = state_q;
        out_d   = out;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_CHECK;
            ST_CHECK: begin
                if (special) begin
                    out_d   = special_res;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_DIVIDE: if (cnt_q == '0) state_d = ST_NORM;
            ST_NORM: begin
                out_d   = normal_res;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out     <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            out     <= out_d;
            done    <= done_d;
            busy    <= (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            expo_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q <= A;
                        b_q <= B;
                    end
                end
                ST_CHECK: begin
                    rem_q  <= {2'b01, a_q[MB-1:0]};
                    quo_q  <= '0;
                    cnt_q  <= CNT_LOAD;
                    expo_q <= $signed({2'b00, a_q[X-2 -: EB]})
                            - $signed({2'b00, b_q[X-2 -: EB]}) + E_BIAS;
                end
                ST_DIVIDE: begin
                    rem_q <= rem_nx << 1;
                    quo_q <= {quo_q[MB:0], ge};
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
module tb_fp_divider;

    typedef struct {
        logic [63:0] val;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start32 = 1'b0, start64 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] a64 = '0, b64 = '0;
    logic [31:0] out32;
    logic [63:0] out64;
    logic        done32, busy32, done64, busy64;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fp_divider #(.X(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32),
        .out(out32), .done(done32), .busy(busy32)
    );

    fp_divider #(.X(64)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .A(a64), .B(b64),
        .out(out64), .done(done64), .busy(busy64)
    );

    // One 32-bit operation; optional stray start pulsed so it is sampled at edge inject_at.
    task automatic run_op32(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_out, input int exp_lat, input int inject_at);
        exp_t e, got_e;
        int   edge_n;
        bit   got, busy_bad;
        e.val = {32'h0, exp_out};
        e.lat = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom;
        edge_n = 1; got = 0; busy_bad = (busy32 !== 1'b1);
        while (!got && edge_n < 100) begin
            start32 = (inject_at != 0 && edge_n == inject_at - 1);
            @(posedge clk); #1;
            edge_n++;
            if (busy32 !== 1'b1) busy_bad = 1;
            if (done32 === 1'b1) got = 1;
        end
        start32 = 1'b0;
        got_e = sb.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s timeout: done never seen within %0d edges", name, edge_n);
            return;
        end
        checks++;
        if (out32 !== got_e.val[31:0]) begin
            failures++;
            $display("FAIL %s out: got %h expected %h", name, out32, got_e.val[31:0]);
        end
        checks++;
        if (edge_n != got_e.lat) begin
            failures++;
            $display("FAIL %s latency: got edge %0d expected edge %0d", name, edge_n, got_e.lat);
        end
        checks++;
        if (busy_bad) begin
            failures++;
            $display("FAIL %s busy: dropped before done, got 0 expected 1", name);
        end
        @(posedge clk); #1;
        checks++;
        if (done32 !== 1'b0 || busy32 !== 1'b0 || out32 !== got_e.val[31:0]) begin
            failures++;
            $display("FAIL %s after-done: got done=%b busy=%b out=%h expected 0 0 %h",
                     name, done32, busy32, out32, got_e.val[31:0]);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out32 !== '0 || done32 !== 1'b0 || busy32 !== 1'b0 ||
            out64 !== '0 || done64 !== 1'b0 || busy64 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got %h/%b/%b %h/%b/%b expected all zero",
                     out32, done32, busy32, out64, done64, busy64);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_normal();
        run_op32("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 28, 0);
        run_op32("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28, 0);
        run_op32("ten_by_five",  32'h41200000, 32'h40A00000, 32'h40000000, 28, 0);
        run_op32("neg_six_by_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 28, 0);
    endtask

    task automatic test_specials();
        run_op32("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 2, 0);
        run_op32("five_by_zero", 32'h40A00000, 32'h00000000, 32'h7F800000, 2, 0);
        run_op32("negone_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 2, 0);
        run_op32("nan_by_one",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2, 0);
        run_op32("nan_by_neg",   32'h7FC00001, 32'hBF800000, 32'hFFC00000, 2, 0);
        run_op32("inf_by_inf",   32'h7F800000, 32'hFF800000, 32'hFFC00000, 2, 0);
        run_op32("five_by_inf",  32'h40A00000, 32'h7F800000, 32'h00000000, 2, 0);
        run_op32("subnorm_flush", 32'h00000001, 32'h3F800000, 32'h00000000, 2, 0);
        run_op32("negzero_by_one", 32'h80000000, 32'h3F800000, 32'h80000000, 2, 0);
    endtask

    task automatic test_range();
        run_op32("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 28, 0);
        run_op32("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 28, 0);
    endtask

    task automatic test_control();
        bit saw_done;
        run_op32("start_in_divide", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28, 6);
        // Abandon an operation with reset shortly before edge 10.
        @(negedge clk);
        a32 = 32'h40C00000; b32 = 32'h40000000; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out32 !== '0 || done32 !== 1'b0 || busy32 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got out=%h done=%b busy=%b expected 0 0 0",
                     out32, done32, busy32);
        end
        @(negedge clk); rst = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 !== 1'b0) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL abandoned_done: got a done pulse expected none");
        end
        run_op32("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 0);
    endtask

    task automatic test_back_to_back();
        run_op32("b2b_first",  32'h3F800000, 32'h00000000, 32'h7F800000, 2, 0);
        run_op32("b2b_second", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 0);
        run_op32("b2b_third",  32'h00000000, 32'h40000000, 32'h00000000, 2, 0);
    endtask

    task automatic test_double();
        exp_t e, got_e;
        int   edge_n;
        bit   got;
        e.val = 64'h4008000000000000;
        e.lat = 57;
        sb.push_back(e);
        @(negedge clk);
        a64 = 64'h4018000000000000; b64 = 64'h4000000000000000; start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        edge_n = 1; got = 0;
        while (!got && edge_n < 200) begin
            @(posedge clk); #1;
            edge_n++;
            if (done64 === 1'b1) got = 1;
        end
        got_e = sb.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL dbl timeout: done never seen within %0d edges", edge_n);
        end else begin
            checks++;
            if (out64 !== got_e.val) begin
                failures++;
                $display("FAIL dbl out: got %h expected %h", out64, got_e.val);
            end
            checks++;
            if (edge_n != got_e.lat) begin
                failures++;
                $display("FAIL dbl latency: got edge %0d expected edge %0d", edge_n, got_e.lat);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_range();
        test_control();
        test_back_to_back();
        test_double();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
